// File: rtl/imem_loader.sv
// imem_loader: program-load controller for the instruction memory programming
// port. Accepts a framed byte stream (sync, 16-bit word count, little-endian
// payload words, XOR checksum), writes the assembled words from address 0
// upwards and holds the CPU in reset while an image is being replaced.
module imem_loader #(
    parameter int INST_MEMORY_SIZE = 16384,
    parameter int ADDR_WIDTH       = $clog2(INST_MEMORY_SIZE),
    parameter int MAX_WORDS        = INST_MEMORY_SIZE / 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [31:0]           write_data,
    output logic                  w_en,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error
);

    // One bit wider than a word address so that a count of MAX_WORDS fits.
    localparam int          IDX_W     = ADDR_WIDTH - 1;
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [15:0] MAX_LEN   = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CHK    = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    // Running checksum update: XOR of every payload byte.
    function automatic logic [7:0] csum_update(input logic [7:0] acc,
                                               input logic [7:0] data_byte);
        return acc ^ data_byte;
    endfunction

    state_t                  state_r, state_nxt_s;
    logic [7:0]              len_lo_r, len_lo_nxt_s;
    logic [15:0]             len_r, len_nxt_s;
    logic [15:0]             len_in_s;
    logic [IDX_W-1:0]        word_idx_r, word_idx_nxt_s;
    logic [IDX_W-1:0]        widx_inc_s;
    logic [1:0]              byte_cnt_r, byte_cnt_nxt_s;
    logic [31:0]             word_r, word_nxt_s;
    logic [7:0]              csum_r, csum_nxt_s;
    logic                    in_ready_r, in_ready_nxt_s;
    logic                    w_en_r, w_en_nxt_s;
    logic [ADDR_WIDTH-1:0]   write_addr_r, write_addr_nxt_s;
    logic [31:0]             write_data_r, write_data_nxt_s;
    logic                    cpu_hold_r, cpu_hold_nxt_s;
    logic                    load_done_r, load_done_nxt_s;
    logic                    load_error_r, load_error_nxt_s;
    logic                    fire_s;

    assign fire_s     = in_valid && in_ready_r;
    assign len_in_s   = {in_data, len_lo_r};
    assign widx_inc_s = word_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};

    assign in_ready   = in_ready_r;
    assign w_en       = w_en_r;
    assign write_addr = write_addr_r;
    assign write_data = write_data_r;
    assign cpu_hold   = cpu_hold_r;
    assign load_done  = load_done_r;
    assign load_error = load_error_r;

    // Next-state and next-output computation for the load FSM.
    always_comb begin
        state_nxt_s      = state_r;
        len_lo_nxt_s     = len_lo_r;
        len_nxt_s        = len_r;
        word_idx_nxt_s   = word_idx_r;
        byte_cnt_nxt_s   = byte_cnt_r;
        word_nxt_s       = word_r;
        csum_nxt_s       = csum_r;
        w_en_nxt_s       = 1'b0;
        write_addr_nxt_s = write_addr_r;
        write_data_nxt_s = write_data_r;
        cpu_hold_nxt_s   = cpu_hold_r;
        load_done_nxt_s  = load_done_r;
        load_error_nxt_s = load_error_r;

        case (state_r)
            // Idle, finished and failed all wait for a sync byte; anything
            // else is swallowed so a noisy line cannot stall the sender.
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (fire_s && (in_data == SYNC_BYTE)) begin
                    state_nxt_s      = ST_LEN_LO;
                    cpu_hold_nxt_s   = 1'b1;
                    load_done_nxt_s  = 1'b0;
                    load_error_nxt_s = 1'b0;
                    word_idx_nxt_s   = {IDX_W{1'b0}};
                    csum_nxt_s       = 8'h00;
                end else begin
                    state_nxt_s      = state_r;
                end
            end

            ST_LEN_LO: begin
                if (fire_s) begin
                    len_lo_nxt_s = in_data;
                    state_nxt_s  = ST_LEN_HI;
                end else begin
                    state_nxt_s  = ST_LEN_LO;
                end
            end

            ST_LEN_HI: begin
                if (fire_s) begin
                    len_nxt_s      = len_in_s;
                    byte_cnt_nxt_s = 2'd0;
                    if (len_in_s > MAX_LEN) begin
                        state_nxt_s      = ST_ERR;
                        load_error_nxt_s = 1'b1;
                    end else if (len_in_s == 16'h0000) begin
                        state_nxt_s      = ST_CHK;
                    end else begin
                        state_nxt_s      = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_LEN_HI;
                end
            end

            ST_DATA: begin
                if (fire_s) begin
                    word_nxt_s[{byte_cnt_r, 3'b000} +: 8] = in_data;
                    csum_nxt_s     = csum_update(csum_r, in_data);
                    byte_cnt_nxt_s = byte_cnt_r + 2'd1;
                    if (byte_cnt_r == 2'd3) begin
                        // Word complete: present it to the memory next cycle.
                        state_nxt_s      = ST_WRITE;
                        w_en_nxt_s       = 1'b1;
                        write_addr_nxt_s = {word_idx_r[IDX_W-2:0], 2'b00};
                        write_data_nxt_s = {in_data, word_r[23:0]};
                    end else begin
                        state_nxt_s      = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end

            ST_WRITE: begin
                word_idx_nxt_s = widx_inc_s;
                if (16'(widx_inc_s) == len_r) begin
                    state_nxt_s = ST_CHK;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end

            ST_CHK: begin
                if (fire_s) begin
                    if (in_data == csum_r) begin
                        state_nxt_s     = ST_DONE;
                        load_done_nxt_s = 1'b1;
                        cpu_hold_nxt_s  = 1'b0;
                    end else begin
                        state_nxt_s      = ST_ERR;
                        load_error_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_CHK;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // The sender is stalled only for the single write cycle.
        in_ready_nxt_s = (state_nxt_s != ST_WRITE);
    end

    // State and registered outputs; asynchronous reset lets the CPU run the
    // existing image immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            len_lo_r     <= 8'h00;
            len_r        <= 16'h0000;
            word_idx_r   <= {IDX_W{1'b0}};
            byte_cnt_r   <= 2'd0;
            word_r       <= 32'h0000_0000;
            csum_r       <= 8'h00;
            in_ready_r   <= 1'b1;
            w_en_r       <= 1'b0;
            write_addr_r <= {ADDR_WIDTH{1'b0}};
            write_data_r <= 32'h0000_0000;
            cpu_hold_r   <= 1'b0;
            load_done_r  <= 1'b0;
            load_error_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            len_lo_r     <= len_lo_nxt_s;
            len_r        <= len_nxt_s;
            word_idx_r   <= word_idx_nxt_s;
            byte_cnt_r   <= byte_cnt_nxt_s;
            word_r       <= word_nxt_s;
            csum_r       <= csum_nxt_s;
            in_ready_r   <= in_ready_nxt_s;
            w_en_r       <= w_en_nxt_s;
            write_addr_r <= write_addr_nxt_s;
            write_data_r <= write_data_nxt_s;
            cpu_hold_r   <= cpu_hold_nxt_s;
            load_done_r  <= load_done_nxt_s;
            load_error_r <= load_error_nxt_s;
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program-load controller that drives the write-only programming port of the instruction memory. It receives a framed byte stream (typically from a UART receiver) over a valid/ready handshake. It assembles little-endian 32-bit words, writes them to consecutive word slots starting at address 0, and verifies an XOR checksum. While a load is in progress it holds the CPU in reset so the fetch port never observes a partially written image.

## Interface
- `INST_MEMORY_SIZE`, 16384, instruction memory size in bytes
- `ADDR_WIDTH`, `$clog2(INST_MEMORY_SIZE)`, byte-address width of the programming port
- `MAX_WORDS`, `INST_MEMORY_SIZE/4`, largest legal word count per load

- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_data`  in  8  incoming stream byte
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  loader can accept a byte this cycle
- `write_addr`  out  ADDR_WIDTH  byte address to the memory programming port (always word aligned, bits[1:0]=0)
- `write_data`  out  32  word to write
- `w_en`  out  1  write strobe, one cycle per word
- `cpu_hold`  out  1  high = CPU held in reset
- `load_done`  out  1  last load completed with good checksum
- `load_error`  out  1  last load failed (bad length or checksum)

## Operation
- Frame format: `0xA5` sync, `LEN_LO`, `LEN_HI`, then LEN×4 payload bytes (LSB first per word), then 1 checksum byte = XOR of all payload bytes.
- A byte transfers on a rising edge with `in_valid && in_ready`.
- States:
  - **IDLE**: non-`0xA5` bytes are consumed and discarded. `0xA5` sets `cpu_hold`=1, clears `load_done`/`load_error`, zeroes the word index and checksum, and moves to LEN_LO.
  - **LEN_LO**: captures the low length byte, then LEN_HI.
  - **LEN_HI**: forms the 16-bit LEN.
    - LEN > `MAX_WORDS` → ERR.
    - LEN = 0 → CHK.
    - Otherwise → DATA.
  - **DATA**: the byte counter (0..3) places each byte at bits [8k+7:8k] of the word shift register and XORs it into the checksum. After the 4th byte → WRITE.
  - **WRITE**: one cycle with `in_ready`=0. `w_en`=1, `write_addr`=word_index<<2, `write_data`=assembled word. The word index then increments. If the index now equals LEN → CHK, else → DATA.
  - **CHK**: the received byte is compared with the running XOR. Equal → DONE, else → ERR.
  - **DONE**: `load_done`=1, `cpu_hold`=0. A `0xA5` byte restarts the load as in IDLE. Other bytes are discarded.
  - **ERR**: `load_error`=1, `cpu_hold` stays 1. A `0xA5` byte restarts the load. Other bytes are discarded.
- `in_ready`=1 in every state except WRITE.
- Words beyond LEN are never written. Memory above LEN×4 keeps its previous contents.
- Word index width is ADDR_WIDTH-1 bits so that a count of `MAX_WORDS` fits. `write_addr` never wraps because LEN ≤ `MAX_WORDS`.

## Timing
- Reset values: state IDLE, `in_ready` 1, `w_en` 0, `write_addr` 0, `write_data` 0, `cpu_hold` 0 (CPU runs the initialization image), `load_done` 0, `load_error` 0.
- All outputs are registered. No combinational path from `in_valid` or `in_data` to any output.
- `cpu_hold` rises on the cycle after the sync byte is accepted.
- `w_en` pulses exactly one cycle, on the cycle after the 4th byte of a word is accepted.
- Minimum frame cost is 5 cycles per word (4 byte cycles + 1 WRITE). The sender stalls via `in_ready`.
- `load_done`/`cpu_hold`=0 appear the cycle after the checksum byte is accepted.
- Gaps in `in_valid` are legal anywhere. State and partial words are held indefinitely.
- Asynchronous `rst_n` assertion mid-load: all outputs take their reset values immediately. The partial image stays in memory; the CPU restarts from it.
- A `0xA5` value inside the length, payload or checksum fields is data, not sync.

## Test plan
- Reset, then the frame A5 02 00 | 11 22 33 44 | 55 66 77 88 | checksum 0x88:
  - `w_en` pulses twice: addr 0x0000 data 0x44332211, then addr 0x0004 data 0x88776655.
  - `load_done`=1, `cpu_hold`=0.
- Same frame with checksum 0x00 → both writes occur, `load_error`=1, `cpu_hold` stays 1, `load_done`=0. A following correct frame → `load_done`=1.
- A5 00 00 00 → no `w_en`, `load_done`=1.
- A5 01 10 (LEN=0x1001 > 4096) → ERR immediately, no writes, `cpu_hold`=1.
- Garbage bytes 00 FF 12 before a valid frame are discarded with `cpu_hold`=0 throughout. Random `in_valid` gaps inside payload bytes → identical write sequence to the gap-free case.
- Drop `rst_n` after the 2nd payload byte → outputs at reset values asynchronously. A new full frame then loads correctly from addr 0.
